// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
// Shared definitions for the SDRAM request arbiter: default bus widths,
// the command FSM state encoding and a grant-index width helper.
package sdram_arb_pkg;

    localparam int ADDR_W_DEF = 25;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ACK,
        WAIT_DATA,
        DONE
    } arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_req_arbiter_if.sv
// sdram_req_arbiter_if
// Bundles the requester-side handshake and the SDRAM-controller command
// bus of the arbiter.
//   master : arbiter view (takes requests, drives controller strobes)
//   slave  : environment view (requesters + SDRAM controller)
// Requester side : req_valid/req_we/req_addr/req_wdata in,
//                  req_ready/rsp_valid/rsp_data/err out
// Controller side: read/write/addr/wdata out, busy/read_ready/rdata in
interface sdram_req_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_we;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr;
    logic [NREQ-1:0][DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]           rsp_data;
    logic                        err;

    logic                        read;
    logic                        write;
    logic [ADDR_W-1:0]           addr;
    logic [DATA_W-1:0]           wdata;
    logic                        busy;
    logic                        read_ready;
    logic [DATA_W-1:0]           rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, err,
        output read, write, addr, wdata,
        input  busy, read_ready, rdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, err,
        input  read, write, addr, wdata,
        output busy, read_ready, rdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick: the first active request found when
// scanning upward (with wrap) from last_grant+1.
//   req        in  NREQ   active requests
//   last_grant in  IDX_W  index granted most recently
//   grant      out NREQ   one-hot winner (all zero if no request)
//   idx        out IDX_W  winner index (0 if no request)
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    int c;

    // Scan from lowest to highest priority so the last hit, i.e. the
    // requester closest after last_grant, is the one that sticks.
    always_comb begin
        grant = '0;
        idx   = '0;
        c     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            c = int'(last_grant) + k;
            if (c >= NREQ) c = c - NREQ;
            if (req[IDX_W'(c)]) begin
                grant              = '0;
                grant[IDX_W'(c)]   = 1'b1;
                idx                = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter
// Shares one SDRAM controller among NREQ requesters. One command is in
// flight at a time: grant (req_ready pulse), issue a read/write strobe once
// the controller is idle, hold it until busy rises, collect read data,
// then report completion (rsp_valid pulse) once busy falls. A strobe that
// never sees busy rise within TIMEOUT cycles is abandoned with an err pulse.
//   clk100 in  system clock
//   rst    in  synchronous active-high reset
//   bus    master modport of sdram_req_arbiter_if (requester + controller)
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk100,
    input  logic                 rst,
    sdram_req_arbiter_if.master  bus
);

    localparam int IDX_W = idx_w(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e        state, state_nxt;
    logic              busy_last;
    logic              busy_rise;
    logic              we_q;
    logic [NREQ-1:0]   gnt_q;
    logic [IDX_W-1:0]  last_grant;
    logic [CNT_W-1:0]  cnt;
    logic              timed_out;
    logic              any_req;
    logic [NREQ-1:0]   grant_oh;
    logic [IDX_W-1:0]  grant_idx;

    logic [NREQ-1:0]   req_ready_d;
    logic [NREQ-1:0]   rsp_valid_d;
    logic              err_d;
    logic              strobe_d;

    assign busy_rise = bus.busy & ~busy_last;
    assign timed_out = (cnt == CNT_W'(TIMEOUT));
    assign any_req   = |bus.req_valid;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant_oh),
        .idx        (grant_idx)
    );

    // State register
    always_ff @(posedge clk100) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (any_req)        state_nxt = ISSUE;
            ISSUE:     if (!bus.busy)      state_nxt = ACK;
            ACK: begin
                if (busy_rise)             state_nxt = we_q ? DONE : WAIT_DATA;
                else if (timed_out)        state_nxt = IDLE;
            end
            WAIT_DATA: if (bus.read_ready) state_nxt = DONE;
            DONE:      if (!bus.busy)      state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // Output decode: next values of the registered pulses and strobe.
    // The strobe is asserted from the ISSUE->ACK edge and kept for every
    // ACK cycle that is not about to leave ACK.
    always_comb begin
        req_ready_d = '0;
        rsp_valid_d = '0;
        err_d       = 1'b0;
        strobe_d    = 1'b0;
        case (state)
            IDLE:    if (any_req) req_ready_d = grant_oh;
            ISSUE:   strobe_d = ~bus.busy;
            ACK: begin
                strobe_d = ~busy_rise & ~timed_out;
                err_d    = ~busy_rise &  timed_out;
            end
            DONE:    if (!bus.busy) rsp_valid_d = gnt_q;
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk100) begin
        if (rst) begin
            busy_last     <= 1'b0;
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            bus.err       <= 1'b0;
            bus.read      <= 1'b0;
            bus.write     <= 1'b0;
            bus.addr      <= '0;
            bus.wdata     <= '0;
            bus.rsp_data  <= '0;
            we_q          <= 1'b0;
            gnt_q         <= '0;
            last_grant    <= IDX_W'(NREQ - 1);
            cnt           <= '0;
        end else begin
            busy_last     <= bus.busy;
            bus.req_ready <= req_ready_d;
            bus.rsp_valid <= rsp_valid_d;
            bus.err       <= err_d;
            bus.read      <= strobe_d & ~we_q;
            bus.write     <= strobe_d &  we_q;

            if (state == IDLE && any_req) begin
                last_grant <= grant_idx;
                gnt_q      <= grant_oh;
                we_q       <= bus.req_we[grant_idx];
                bus.addr   <= bus.req_addr[grant_idx];
                bus.wdata  <= bus.req_wdata[grant_idx];
            end

            // Counter restarts at issue and saturates at TIMEOUT in ACK.
            if (state == ISSUE)
                cnt <= '0;
            else if (state == ACK && !timed_out)
                cnt <= cnt + 1'b1;

            if (state == WAIT_DATA && bus.read_ready)
                bus.rsp_data <= bus.rdata;
        end
    end

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb_sdram_req_arbiter
// Directed bench for sdram_req_arbiter: reset values, single write, single
// read with stale read_ready, round-robin contention, timeout, reset during
// a strobe and a controller that is busy at issue. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_sdram_req_arbiter;

    localparam int TO = 20;

    logic clk100 = 1'b0;
    logic rst    = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] acc;

    always #5 clk100 = ~clk100;

    sdram_req_arbiter_if #(.NREQ(3), .ADDR_W(25), .DATA_W(16)) bus ();

    sdram_req_arbiter #(.ADDR_W(25), .DATA_W(16), .NREQ(3), .TIMEOUT(TO)) dut (
        .clk100 (clk100),
        .rst    (rst),
        .bus    (bus.master)
    );

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Controller side of one command from the strobe onwards: busy rises
    // on the first strobe cycle, read data (if any) follows, busy falls.
    task automatic finish_cmd(input int idx, input logic we, input logic [15:0] d, input string tag);
        int n = 0;
        while (!(bus.read || bus.write) && n < 40) begin
            @(negedge clk100);
            n++;
        end
        chk({tag, "_strb"}, 32'({bus.read, bus.write}), we ? 32'd1 : 32'd2);
        bus.busy = 1'b1;
        @(negedge clk100);
        chk({tag, "_drop"}, 32'(bus.read | bus.write), 32'd0);
        if (!we) begin
            bus.read_ready = 1'b1;
            bus.rdata      = d;
        end
        bus.busy = 1'b0;
        @(negedge clk100);
        bus.read_ready = 1'b0;
        bus.rdata      = '0;
        if (!we) @(negedge clk100);
        chk({tag, "_rsp"}, 32'(bus.rsp_valid), 32'(1) << idx);
        if (!we) chk({tag, "_rdat"}, 32'(bus.rsp_data), 32'(d));
    endtask

    task automatic serve(input int idx, input logic we, input logic [24:0] a,
                         input logic [15:0] d, input string tag);
        int n = 0;
        while (bus.req_ready == 3'b000 && n < 40) begin
            @(negedge clk100);
            n++;
        end
        chk({tag, "_gnt"}, 32'(bus.req_ready), 32'(1) << idx);
        chk({tag, "_addr"}, 32'(bus.addr), 32'(a));
        if (we) chk({tag, "_wdat"}, 32'(bus.wdata), 32'(d));
        finish_cmd(idx, we, d, tag);
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_we     = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.busy       = 1'b0;
        bus.read_ready = 1'b0;
        bus.rdata      = '0;

        // Reset values
        repeat (3) @(negedge clk100);
        chk("rst_read",  32'(bus.read),      32'd0);
        chk("rst_write", 32'(bus.write),     32'd0);
        chk("rst_rdy",   32'(bus.req_ready), 32'd0);
        chk("rst_rsp",   32'(bus.rsp_valid), 32'd0);
        chk("rst_err",   32'(bus.err),       32'd0);
        chk("rst_addr",  32'(bus.addr),      32'd0);
        chk("rst_wdat",  32'(bus.wdata),     32'd0);
        chk("rst_rdat",  32'(bus.rsp_data),  32'd0);
        rst = 1'b0;

        // Single write, busy rises on the third strobe cycle
        bus.req_valid    = 3'b001;
        bus.req_we       = 3'b001;
        bus.req_addr[0]  = 25'h000010;
        bus.req_wdata[0] = 16'h1234;
        @(negedge clk100);
        chk("w_rdy",  32'(bus.req_ready), 32'd1);
        chk("w_addr", 32'(bus.addr),      32'h10);
        chk("w_wdat", 32'(bus.wdata),     32'h1234);
        chk("w_nostrb", 32'(bus.write),   32'd0);
        bus.req_valid = 3'b000;
        @(negedge clk100);
        chk("w_strb1", 32'({bus.read, bus.write}), 32'd1);
        chk("w_rdy_once", 32'(bus.req_ready), 32'd0);
        @(negedge clk100);
        chk("w_strb2", 32'(bus.write), 32'd1);
        @(negedge clk100);
        chk("w_strb3", 32'(bus.write), 32'd1);
        bus.busy = 1'b1;
        @(negedge clk100);
        chk("w_strb_off", 32'(bus.write), 32'd0);
        chk("w_rsp_early", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk100);
        chk("w_rsp_busy", 32'(bus.rsp_valid), 32'd0);
        bus.busy = 1'b0;
        @(negedge clk100);
        chk("w_rsp", 32'(bus.rsp_valid), 32'd1);
        chk("w_err", 32'(bus.err),       32'd0);
        @(negedge clk100);
        chk("w_rsp_pulse", 32'(bus.rsp_valid), 32'd0);

        // Single read; read_ready before WAIT_DATA must be ignored
        bus.req_valid   = 3'b010;
        bus.req_we      = 3'b000;
        bus.req_addr[1] = 25'h000020;
        bus.read_ready  = 1'b1;
        bus.rdata       = 16'hDEAD;
        @(negedge clk100);
        chk("r_rdy",  32'(bus.req_ready), 32'd2);
        chk("r_addr", 32'(bus.addr),      32'h20);
        bus.req_valid = 3'b000;
        @(negedge clk100);
        chk("r_strb", 32'({bus.read, bus.write}), 32'd2);
        bus.read_ready = 1'b0;
        bus.rdata      = '0;
        bus.busy       = 1'b1;
        @(negedge clk100);
        chk("r_strb_off", 32'(bus.read), 32'd0);
        chk("r_stale",    32'(bus.rsp_data), 32'd0);
        bus.read_ready = 1'b1;
        bus.rdata      = 16'hBEEF;
        @(negedge clk100);
        bus.read_ready = 1'b0;
        bus.rdata      = '0;
        bus.busy       = 1'b0;
        chk("r_rsp_early", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk100);
        chk("r_rsp",  32'(bus.rsp_valid), 32'd2);
        chk("r_rdat", 32'(bus.rsp_data),  32'hBEEF);
        @(negedge clk100);
        chk("r_hold", 32'(bus.rsp_data),  32'hBEEF);
        chk("r_rsp_pulse", 32'(bus.rsp_valid), 32'd0);

        // Contention after reset: order 0,1,2,0,1,2
        rst = 1'b1;
        @(negedge clk100);
        rst = 1'b0;
        bus.req_we       = 3'b111;
        bus.req_addr[0]  = 25'h100;
        bus.req_addr[1]  = 25'h200;
        bus.req_addr[2]  = 25'h300;
        bus.req_wdata[0] = 16'hA000;
        bus.req_wdata[1] = 16'hA111;
        bus.req_wdata[2] = 16'hA222;
        bus.req_valid    = 3'b111;
        serve(0, 1'b1, 25'h100, 16'hA000, "c0");
        serve(1, 1'b1, 25'h200, 16'hA111, "c1");
        serve(2, 1'b1, 25'h300, 16'hA222, "c2");
        serve(0, 1'b1, 25'h100, 16'hA000, "c3");
        serve(1, 1'b1, 25'h200, 16'hA111, "c4");
        serve(2, 1'b1, 25'h300, 16'hA222, "c5");
        bus.req_valid = 3'b000;

        // Timeout: busy never rises; pending requester 1 served afterwards
        @(negedge clk100);
        bus.req_valid    = 3'b001;
        bus.req_we       = 3'b001;
        bus.req_addr[0]  = 25'h40;
        bus.req_wdata[0] = 16'h4444;
        @(negedge clk100);
        chk("t_rdy", 32'(bus.req_ready), 32'd1);
        bus.req_valid   = 3'b010;
        bus.req_addr[1] = 25'h50;
        @(negedge clk100);
        chk("t_strb", 32'(bus.write), 32'd1);
        repeat (TO) @(negedge clk100);
        chk("t_strb_last", 32'(bus.write), 32'd1);
        chk("t_err_early", 32'(bus.err),   32'd0);
        @(negedge clk100);
        chk("t_err",    32'(bus.err),       32'd1);
        chk("t_strb_0", 32'(bus.write),     32'd0);
        chk("t_norsp",  32'(bus.rsp_valid), 32'd0);
        @(negedge clk100);
        chk("t_err_pulse", 32'(bus.err),    32'd0);
        bus.req_valid = 3'b000;
        serve(1, 1'b0, 25'h50, 16'h5A5A, "t_next");

        // Reset while the write strobe is up
        @(negedge clk100);
        bus.req_valid    = 3'b100;
        bus.req_we       = 3'b100;
        bus.req_addr[2]  = 25'h77;
        bus.req_wdata[2] = 16'h7777;
        @(negedge clk100);
        chk("x_rdy", 32'(bus.req_ready), 32'd4);
        bus.req_valid = 3'b000;
        @(negedge clk100);
        chk("x_strb", 32'(bus.write), 32'd1);
        rst = 1'b1;
        @(negedge clk100);
        chk("x_write", 32'(bus.write),     32'd0);
        chk("x_rdy0",  32'(bus.req_ready), 32'd0);
        chk("x_err",   32'(bus.err),       32'd0);
        chk("x_addr",  32'(bus.addr),      32'd0);
        chk("x_wdat",  32'(bus.wdata),     32'd0);
        chk("x_rdat",  32'(bus.rsp_data),  32'd0);
        rst = 1'b0;
        acc = '0;
        repeat (5) begin
            @(negedge clk100);
            acc = acc | 32'(bus.rsp_valid) | 32'(bus.read | bus.write);
        end
        chk("x_quiet", acc, 32'd0);

        // Controller busy at issue for 10 cycles
        bus.busy         = 1'b1;
        bus.req_valid    = 3'b001;
        bus.req_we       = 3'b001;
        bus.req_addr[0]  = 25'h99;
        bus.req_wdata[0] = 16'h9999;
        @(negedge clk100);
        chk("b_rdy", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 3'b000;
        acc = '0;
        repeat (10) begin
            @(negedge clk100);
            acc = acc | 32'(bus.read | bus.write);
        end
        chk("b_nostrb", acc, 32'd0);
        bus.busy = 1'b0;
        @(negedge clk100);
        chk("b_strb", 32'(bus.write), 32'd1);
        finish_cmd(0, 1'b1, 16'h9999, "b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
